shift_right_sipo_rx: RTL and testbench

- Serial-in/parallel-out receiver that sits at the far end of the shift-right PISO link.
- Accepts one bit per qualified cycle, LSB first, and reassembles WIDTH-bit words.
- Each completed word is presented on a held output register with a valid/ack handshake and an overrun flag.
- Used wherever a PISO stream must be turned back into parallel data.

---
 rtl/shift_right_sipo_rx_pkg.sv | 15 +
 rtl/shift_right_sipo_rx_if.sv | 28 ++
 rtl/shift_right_sipo_rx_bit_counter.sv | 28 ++
 rtl/shift_right_sipo_rx.sv | 107 ++++++++++
 tb/tb_shift_right_sipo_rx.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/shift_right_sipo_rx_pkg.sv
// Shared types and sizing helpers for the shift-right SIPO receiver.
package sipo_pkg;

    localparam int SIPO_DEFAULT_WIDTH = 4;

    typedef enum logic {
        IDLE,
        RECV
    } sipo_state_t;

    function automatic int sipo_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_right_sipo_rx_if.sv
// Serial input, handshake and status bundle between the SIPO receiver and its consumer.
interface shift_right_sipo_rx_if
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_DEFAULT_WIDTH
);
    localparam int CNT_W = sipo_cnt_w(WIDTH);

    logic             shift_en;
    logic             serial_data_in;
    logic             clear;
    logic             data_ack;
    logic [WIDTH-1:0] parallel_data_out;
    logic             data_valid;
    logic             overrun;
    logic [CNT_W-1:0] bit_count;

    modport master (
        output shift_en, serial_data_in, clear, data_ack,
        input  parallel_data_out, data_valid, overrun, bit_count
    );

    modport slave (
        input  shift_en, serial_data_in, clear, data_ack,
        output parallel_data_out, data_valid, overrun, bit_count
    );

endinterface

// File: rtl/shift_right_sipo_rx_bit_counter.sv
// Counts received bits of the current word; wrap flags the bit that completes it.
module sipo_bit_counter
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_DEFAULT_WIDTH,
    localparam int CNT_W = sipo_cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    assign wrap = inc & ~clear & (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= wrap ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/shift_right_sipo_rx.sv
// Shift-right SIPO receiver: rebuilds LSB-first serial words and holds them under valid/ack.
module shift_right_sipo_rx
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    shift_right_sipo_rx_if.slave bus
);

    localparam int CNT_W = sipo_cnt_w(WIDTH);

    sipo_state_t      state, state_nxt;
    logic [WIDTH-1:1] shreg;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] pdo_q;
    logic             valid_q;
    logic             overrun_q;
    logic [CNT_W-1:0] count;
    logic             wrap;
    logic             shift;
    logic             word_done;
    logic             capture;
    logic             drop;
    logic             release_v;

    // clear discards the incoming bit, so it also masks the shift itself
    assign shift = bus.shift_en & ~bus.clear;

    // Bit 0 of the shift register is only ever consumed as part of a completed
    // word, so only the upper WIDTH-1 bits are kept between shifts.
    assign word = {bus.serial_data_in, shreg};

    sipo_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .clear (bus.clear),
        .inc   (shift),
        .count (count),
        .wrap  (wrap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus.clear) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (shift) state_nxt = RECV;
                RECV: if (wrap)  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        word_done = (state == RECV) & wrap;
        capture   = word_done & (~valid_q | bus.data_ack);
        drop      = word_done & valid_q & ~bus.data_ack;
        release_v = ~word_done & valid_q & bus.data_ack;
    end

    always_ff @(posedge clk) begin
        if (reset || bus.clear) begin
            shreg <= '0;
        end else if (shift) begin
            shreg <= word[WIDTH-1:1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pdo_q   <= '0;
            valid_q <= 1'b0;
        end else if (capture) begin
            pdo_q   <= word;
            valid_q <= 1'b1;
        end else if (release_v) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.clear) begin
            overrun_q <= 1'b0;
        end else if (drop) begin
            overrun_q <= 1'b1;
        end
    end

    assign bus.parallel_data_out = pdo_q;
    assign bus.data_valid        = valid_q;
    assign bus.overrun           = overrun_q;
    assign bus.bit_count         = count;

endmodule

// File: tb/tb_shift_right_sipo_rx.sv
// Directed plus random bench for shift_right_sipo_rx against a queue-based word model.
module tb_shift_right_sipo_rx;

    localparam int W = 4;

    logic clk = 1'b0;
    logic reset;

    shift_right_sipo_rx_if #(.WIDTH(W)) bus ();

    shift_right_sipo_rx #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_asrt = 0;
    int unsigned n_fail = 0;

    // Model: bits of the partial word in arrival order, plus the held output
    bit         mq[$];
    logic [W-1:0] m_pdo;
    logic       m_dv;
    logic       m_ov;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic se, input logic sd, input logic cl,
                              input logic ak, input logic rs);
        logic         done;
        logic [W-1:0] w;
        done = 1'b0;
        w    = '0;
        if (rs) begin
            mq.delete();
            m_pdo = '0;
            m_dv  = 1'b0;
            m_ov  = 1'b0;
        end else begin
            if (cl) begin
                mq.delete();
                m_ov = 1'b0;
            end else if (se) begin
                mq.push_back(sd);
                if (mq.size() == W) begin
                    foreach (mq[i]) w[i] = mq[i];
                    done = 1'b1;
                    mq.delete();
                end
            end
            if (done) begin
                if (!m_dv || ak) begin
                    m_pdo = w;
                    m_dv  = 1'b1;
                end else begin
                    m_ov = 1'b1;
                end
            end else if (ak) begin
                m_dv = 1'b0;
            end
        end
    endtask

    task automatic cyc(input logic se, input logic sd, input logic cl,
                       input logic ak, input logic rs);
        bus.shift_en       = se;
        bus.serial_data_in = sd;
        bus.clear          = cl;
        bus.data_ack       = ak;
        reset              = rs;
        @(posedge clk);
        model_step(se, sd, cl, ak, rs);
        #1;
        chk("pdo", 32'(bus.parallel_data_out), 32'(m_pdo));
        chk("dv",  32'(bus.data_valid),        32'(m_dv));
        chk("ov",  32'(bus.overrun),           32'(m_ov));
        chk("cnt", 32'(bus.bit_count),         32'(mq.size()));
    endtask

    task automatic bit_in(input logic b, input logic ak);
        cyc(1'b1, b, 1'b0, ak, 1'b0);
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ack_cyc();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic se, sd, cl, ak, rs;
        logic [3:0] gap_bits;
        logic [3:0] w_a;
        logic [3:0] w_b;

        // reset state
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("reset_pdo", 32'(bus.parallel_data_out), 32'h0);
        chk("reset_dv",  32'(bus.data_valid), 32'h0);
        chk("reset_cnt", 32'(bus.bit_count), 32'h0);

        // reset mid-word, then a fresh word 1,0,1,1 -> 1101
        bit_in(1'b1, 1'b0);
        bit_in(1'b1, 1'b0);
        chk("mid_cnt2", 32'(bus.bit_count), 32'h2);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("midrst_cnt", 32'(bus.bit_count), 32'h0);
        chk("midrst_dv",  32'(bus.data_valid), 32'h0);
        chk("midrst_ov",  32'(bus.overrun), 32'h0);
        bit_in(1'b1, 1'b0);
        bit_in(1'b0, 1'b0);
        bit_in(1'b1, 1'b0);
        chk("pre_done_dv", 32'(bus.data_valid), 32'h0);
        bit_in(1'b1, 1'b0);
        chk("fresh_pdo", 32'(bus.parallel_data_out), 32'hD);
        chk("fresh_dv",  32'(bus.data_valid), 32'h1);
        ack_cyc();

        // basic word 0,1,0,1 -> 1010, ack keeps data
        bit_in(1'b0, 1'b0);
        bit_in(1'b1, 1'b0);
        bit_in(1'b0, 1'b0);
        bit_in(1'b1, 1'b0);
        chk("basic_pdo", 32'(bus.parallel_data_out), 32'hA);
        chk("basic_dv",  32'(bus.data_valid), 32'h1);
        ack_cyc();
        chk("ack_dv",  32'(bus.data_valid), 32'h0);
        chk("ack_pdo", 32'(bus.parallel_data_out), 32'hA);
        ack_cyc();
        chk("idle_ack_dv", 32'(bus.data_valid), 32'h0);

        // gapped stream 1,1,0,1 -> 1011
        gap_bits = 4'b1011;
        for (int unsigned i = 0; i < 4; i++) begin
            bit_in(gap_bits[i], 1'b0);
            chk("gap_cnt", 32'(bus.bit_count), (i + 1) % 4);
            idle_cyc();
            idle_cyc();
        end
        chk("gap_pdo", 32'(bus.parallel_data_out), 32'hB);
        ack_cyc();

        // overrun: 1010 then 0011 without ack
        w_a = 4'b1010;
        w_b = 4'b0011;
        for (int unsigned i = 0; i < 4; i++) bit_in(w_a[i], 1'b0);
        for (int unsigned i = 0; i < 4; i++) bit_in(w_b[i], 1'b0);
        chk("ovr_pdo", 32'(bus.parallel_data_out), 32'hA);
        chk("ovr_dv",  32'(bus.data_valid), 32'h1);
        chk("ovr_ov",  32'(bus.overrun), 32'h1);

        // same pair after reset, ack coincident with second completion
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int unsigned i = 0; i < 4; i++) bit_in(w_a[i], 1'b0);
        for (int unsigned i = 0; i < 4; i++) bit_in(w_b[i], i == 3);
        chk("simack_pdo", 32'(bus.parallel_data_out), 32'h3);
        chk("simack_dv",  32'(bus.data_valid), 32'h1);
        chk("simack_ov",  32'(bus.overrun), 32'h0);

        // clear with a held word, overrun set and a partial word
        ack_cyc();
        for (int unsigned i = 0; i < 4; i++) bit_in(w_a[i], 1'b0);
        for (int unsigned i = 0; i < 4; i++) bit_in(1'b1, 1'b0);
        chk("pre_clr_ov", 32'(bus.overrun), 32'h1);
        bit_in(1'b1, 1'b0);
        bit_in(1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("clr_cnt", 32'(bus.bit_count), 32'h0);
        chk("clr_ov",  32'(bus.overrun), 32'h0);
        chk("clr_dv",  32'(bus.data_valid), 32'h1);
        chk("clr_pdo", 32'(bus.parallel_data_out), 32'hA);
        bit_in(1'b1, 1'b0);
        bit_in(1'b0, 1'b0);
        bit_in(1'b0, 1'b0);
        bit_in(1'b0, 1'b1);
        chk("post_clr_pdo", 32'(bus.parallel_data_out), 32'h1);
        chk("post_clr_dv",  32'(bus.data_valid), 32'h1);

        // random traffic
        for (int unsigned n = 0; n < 600; n++) begin
            rs = ($urandom_range(0, 99) < 1);
            se = ($urandom_range(0, 99) < 65);
            sd = 1'($urandom);
            ak = ($urandom_range(0, 99) < 25);
            cl = !ak && ($urandom_range(0, 99) < 3);
            cyc(se, sd, cl, ak, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
